// File: rtl/toggle_hs_rx.sv
// Receiving end of a 2-phase (toggle) req/ack link. Each req_tgl level change
// captures one data_in word into a small FIFO drained over valid/ready.
module toggle_hs_rx #(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_tgl,
  input  logic [DATA_W-1:0]        data_in,
  output logic                     ack_tgl,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   fill_level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_ONE  = LW'(1'b1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1'b1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   req_seen_q, req_seen_d;
  logic                   ack_q, ack_d;
  logic                   valid_q, valid_d;
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]          fill_q, fill_d;
  logic [DATA_W-1:0]      mem_q [DEPTH];
  logic                   req_s, pending_s, push_s, pop_s;

  // Next-state logic: toggle detection, push/pop decisions, pointer and level updates.
  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], req_tgl};
    req_s      = sync_q[SYNC_STAGES-1];
    pending_s  = (req_s != req_seen_q);
    pop_s      = valid_q && out_ready;
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    push_s     = pending_s && ((fill_q < FULL_LVL) || pop_s);
    req_seen_d = req_seen_q;
    ack_d      = ack_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fill_d     = fill_q;

    if (push_s) begin
      req_seen_d = req_s;
      ack_d      = ~ack_q;
      wr_ptr_d   = wr_ptr_q + PTR_ONE;
    end else begin
      req_seen_d = req_seen_q;
      ack_d      = ack_q;
      wr_ptr_d   = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   fill_d = fill_q + LVL_ONE;
      2'b01:   fill_d = fill_q - LVL_ONE;
      default: fill_d = fill_q;
    endcase

    valid_d = (fill_d != {LW{1'b0}});
  end

  // Control state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q     <= {SYNC_STAGES{1'b0}};
      req_seen_q <= 1'b0;
      ack_q      <= 1'b0;
      valid_q    <= 1'b0;
      wr_ptr_q   <= {PW{1'b0}};
      rd_ptr_q   <= {PW{1'b0}};
      fill_q     <= {LW{1'b0}};
    end else begin
      sync_q     <= sync_d;
      req_seen_q <= req_seen_d;
      ack_q      <= ack_d;
      valid_q    <= valid_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_q     <= fill_d;
    end
  end

  // Word storage; deliberately left uncleared by reset.
  always_ff @(posedge clk) begin
    if (rst && push_s) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  assign ack_tgl    = ack_q;
  assign out_valid  = valid_q;
  assign fill_level = fill_q;
  assign out_data   = valid_q ? mem_q[rd_ptr_q] : {DATA_W{1'b0}};

endmodule

// File: tb/tb_toggle_hs_rx.sv
// Self-checking bench for toggle_hs_rx: queue-based reference model plus
// directed handshake scenarios with literal expectations.
module tb_toggle_hs_rx;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int SS    = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_tgl = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] data_in = 8'h00;
  logic          ack_tgl, out_valid;
  logic [DW-1:0] out_data;
  logic [2:0]    fill_level;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  toggle_hs_rx #(.DATA_W(DW), .DEPTH(DEPTH), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .req_tgl(req_tgl), .data_in(data_in),
    .ack_tgl(ack_tgl), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .fill_level(fill_level)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: req_tgl seen SS edges late, words held in a queue of at most DEPTH.
  bit          m_live = 1'b0;
  bit          m_seen, m_ack;
  bit [SS-1:0] m_hist;
  logic [7:0]  m_q[$];

  always @(posedge clk) begin : model_b
    bit rs, pend, pop, push;
    if (!rst) begin
      m_hist = '0; m_seen = 1'b0; m_ack = 1'b0; m_q.delete(); m_live = 1'b1;
    end else begin
      rs   = m_hist[SS-1];
      pend = (rs != m_seen);
      pop  = (m_q.size() != 0) && out_ready;
      push = pend && ((m_q.size() < DEPTH) || pop);
      if (pop) void'(m_q.pop_front());
      if (push) begin
        m_q.push_back(data_in);
        m_seen = rs;
        m_ack  = ~m_ack;
      end
      m_hist = {m_hist[SS-2:0], req_tgl};
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("m_ack",   ack_tgl,    m_ack);
      check("m_valid", out_valid,  m_q.size() != 0);
      check("m_fill",  fill_level, m_q.size());
      check("m_data",  out_data,   (m_q.size() != 0) ? m_q[0] : 8'h00);
    end
  end

  // Pop log and ack-flip counter used by the streaming scenario.
  bit         log_en = 1'b0;
  bit         done = 1'b0;
  int         ack_flips = 0;
  logic       ack_prev = 1'b0;
  logic [7:0] got[$];

  always @(posedge clk) begin
    if (log_en && rst && out_valid && out_ready) got.push_back(out_data);
  end

  always @(negedge clk) begin
    if (log_en && (ack_tgl !== ack_prev)) ack_flips++;
    ack_prev = ack_tgl;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic flip(input logic [7:0] w);
    data_in = w;
    req_tgl = ~req_tgl;
  endtask

  task automatic wait_ack(input int lim);
    int k = 0;
    while ((ack_tgl !== req_tgl) && (k < lim)) begin
      tick(1);
      k++;
    end
    check("ack_wait", ack_tgl, req_tgl);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; tick(3); rst = 1'b1; tick(1);
    check("rst_ack", ack_tgl, 1'b0);
    check("rst_fill", fill_level, 3'd0);
    check("rst_data", out_data, 8'h00);

    // 1: single word, two-edge synchroniser latency then capture
    flip(8'hA5); tick(2);
    check("t1_ack_early", ack_tgl, 1'b0);
    check("t1_valid_early", out_valid, 1'b0);
    tick(1);
    check("t1_ack", ack_tgl, 1'b1);
    check("t1_valid", out_valid, 1'b1);
    check("t1_data", out_data, 8'hA5);
    check("t1_fill", fill_level, 3'd1);
    out_ready = 1'b1; tick(1); out_ready = 1'b0;
    check("t1_fill_pop", fill_level, 3'd0);
    check("t1_data_pop", out_data, 8'h00);

    // 2: fill to DEPTH, fifth toggle held back until a pop frees a slot
    for (int i = 1; i <= 4; i++) begin
      flip(8'(i)); wait_ack(20);
    end
    check("t2_full", fill_level, 3'd4);
    flip(8'h05); tick(20);
    check("t2_ack_held", ack_tgl, 1'b1);
    check("t2_fill_held", fill_level, 3'd4);
    check("t2_head", out_data, 8'h01);
    out_ready = 1'b1; tick(1); out_ready = 1'b0;
    check("t2_ack_after", ack_tgl, 1'b0);
    check("t2_fill_after", fill_level, 3'd4);
    check("t2_head_after", out_data, 8'h02);

    // 3: full FIFO, pending toggle, pop and push in the same edge
    flip(8'h06); tick(2);
    check("t3_pending", ack_tgl, 1'b0);
    out_ready = 1'b1; tick(1);
    check("t3_ack", ack_tgl, 1'b1);
    check("t3_fill", fill_level, 3'd4);
    check("t3_head", out_data, 8'h03);
    tick(4); out_ready = 1'b0;
    check("t3_drained", fill_level, 3'd0);
    check("t3_ack_once", ack_tgl, 1'b1);

    // 4: ten words streamed against random back-pressure
    got.delete(); ack_flips = 0; done = 1'b0; log_en = 1'b1;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          flip(8'h10 + 8'(i)); wait_ack(300);
        end
        done = 1'b1;
      end
      begin
        int k = 0;
        while (!(done && (fill_level == 3'd0)) && (k < 5000)) begin
          out_ready = 1'($urandom_range(0, 1));
          tick(1);
          k++;
        end
        out_ready = 1'b0;
      end
    join
    log_en = 1'b0;
    check("t4_count", got.size(), 10);
    for (int i = 0; i < 10; i++) begin
      check("t4_order", (i < got.size()) ? got[i] : 8'hXX, 8'h10 + 8'(i));
    end
    check("t4_flips", ack_flips, 10);
    check("t4_empty", fill_level, 3'd0);

    // 5: reset while holding words and with a toggle mid-synchroniser
    for (int i = 0; i < 3; i++) begin
      flip(8'h30 + 8'(i)); wait_ack(20);
    end
    check("t5_fill3", fill_level, 3'd3);
    flip(8'h3F); tick(1);
    rst = 1'b0; req_tgl = 1'b0; tick(1); rst = 1'b1;
    check("t5_valid", out_valid, 1'b0);
    check("t5_fill", fill_level, 3'd0);
    check("t5_ack", ack_tgl, 1'b0);
    check("t5_data", out_data, 8'h00);
    tick(10);
    check("t5_no_capture", fill_level, 3'd0);
    check("t5_ack_quiet", ack_tgl, 1'b0);

    // 6: out_ready on an empty FIFO is inert
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("t6_valid", out_valid, 1'b0);
      check("t6_data", out_data, 8'h00);
      check("t6_fill", fill_level, 3'd0);
      check("t6_ack", ack_tgl, 1'b0);
    end
    out_ready = 1'b0;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
